// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//
// Shared definitions for the generic inter-stage pipeline register
// (pipe_stage_reg) and its helpers:
//   - default control/data bundle widths for each pipeline boundary
//     (IF/ID, ID/EX, EX/MEM, MEM/WB)
//   - bit offsets of the fields inside the control bundle
//   - the control value that represents a bubble (all zero)
// -----------------------------------------------------------------------------
package pipe_pkg;

  // ---------------------------------------------------------------------------
  // Per-boundary bundle widths
  // ---------------------------------------------------------------------------
  // IF/ID: no decoded control yet; a single "valid instruction" style bit.
  //        Data = Instruction(32) + PC(32).
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;

  // ID/EX: full control bundle.
  //        Data = PC(32) + RegData1(32) + RegData2(32) + Imm(32) + RegDest(5).
  localparam int IDEX_CTRL_W  = 8;
  localparam int IDEX_DATA_W  = 133;

  // EX/MEM: full control bundle.
  //        Data = ALUResult(32) + Instruction(32) + PC(32) + WriteData(32)
  //               + RegDest(5).
  localparam int EXMEM_CTRL_W = 8;
  localparam int EXMEM_DATA_W = 133;

  // MEM/WB: only the write-back controls survive (RegWrite, MemToReg).
  //        Data = ReadData(32) + ALUResult(32) + RegDest(5).
  localparam int MEMWB_CTRL_W = 3;
  localparam int MEMWB_DATA_W = 69;

  // ---------------------------------------------------------------------------
  // Control bundle layout (8-bit full bundle)
  //   [0]   MemRead
  //   [1]   MemWrite
  //   [2]   RegWrite
  //   [4:3] ByteSel
  //   [6:5] MemToReg
  //   [7]   spare
  // ---------------------------------------------------------------------------
  localparam int MEMREAD_BIT  = 0;
  localparam int MEMWRITE_BIT = 1;
  localparam int REGWRITE_BIT = 2;
  localparam int BYTESEL_LSB  = 3;
  localparam int BYTESEL_W    = 2;
  localparam int MEMTOREG_LSB = 5;
  localparam int MEMTOREG_W   = 2;

  typedef enum logic [1:0] {
    BYTESEL_WORD = 2'd0,
    BYTESEL_HALF = 2'd1,
    BYTESEL_BYTE = 2'd2
  } bytesel_e;

  typedef enum logic [1:0] {
    MEMTOREG_ALU = 2'd0,
    MEMTOREG_MEM = 2'd1,
    MEMTOREG_PC4 = 2'd2
  } memtoreg_e;

  // A bubble carries no side effects: every control bit is clear, so any
  // downstream stage may use the control bits without gating on valid.
  localparam int CTRL_BUBBLE = 0;

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//
// Saturating up-counter with synchronous clear. Used by pipe_stage_reg to
// count stall cycles.
//
// Parameters:
//   CNT_W  counter width; the count sticks at 2^CNT_W-1
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous, active-high reset (count -> 0)
//   inc    in   increment request for this cycle
//   clr    in   synchronous clear; wins over inc on the same edge
//   count  out  current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic inter-stage pipeline register. Carries a control bundle and a data
// bundle between two pipeline stages with a valid/ready handshake, a
// synchronous flush that inserts a bubble, and a saturating stall counter.
//
// Build option:
//   PIPE_SKID_EN  when defined, adds one skid slot so that In_Ready is a
//                 registered signal with no combinational path from
//                 Out_Ready (capacity 2). When undefined, In_Ready is
//                 combinational (~Out_Valid | Out_Ready), capacity 1.
//
// Parameters:
//   CTRL_W  control bundle width (cleared on flush / when not valid)
//   DATA_W  data bundle width (held on flush)
//   CNT_W   stall counter width
//
// Ports:
//   Clock        in   rising-edge clock
//   Reset        in   synchronous, active-high reset
//   Flush        in   drop held entries, insert a bubble; blocks input
//   In_Valid     in   upstream entry valid
//   In_Ready     out  stage accepts an entry this cycle
//   In_Ctrl      in   control bundle in
//   In_Data      in   data bundle in
//   Out_Valid    out  output entry valid
//   Out_Ready    in   downstream accepts
//   Out_Ctrl     out  registered control bundle (0 whenever Out_Valid=0)
//   Out_Data     out  registered data bundle
//   Stall_Count  out  cycles with Out_Valid=1 and Out_Ready=0, saturating
//   Stall_Clr    in   synchronous clear of Stall_Count
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [CNT_W-1:0]  Stall_Count,
  input  logic              Stall_Clr
);

  localparam logic [CTRL_W-1:0] CTRL_ZERO = CTRL_W'(CTRL_BUBBLE);

  // Output register
  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] out_ctrl_q,  out_ctrl_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;

  logic xfer_in;
  logic xfer_out;

  assign xfer_in  = In_Valid & In_Ready;
  assign xfer_out = out_valid_q & Out_Ready;

`ifdef PIPE_SKID_EN
  // ---------------------------------------------------------------------------
  // Skid variant: capacity 2 (output register + skid slot)
  // ---------------------------------------------------------------------------
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  // Ready depends only on the skid flop (and Flush), never on Out_Ready, so
  // the upstream timing path ends at this stage's flops.
  assign In_Ready = ~skid_valid_q & ~Flush;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_ctrl_d   = out_ctrl_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (Flush) begin
      // Both slots dropped; data bits are left as they are.
      out_valid_d  = 1'b0;
      out_ctrl_d   = CTRL_ZERO;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = CTRL_ZERO;
    end else if (!out_valid_q || Out_Ready) begin
      // Output slot is free next cycle: the older skid entry goes first to
      // preserve order. In_Ready is low while the skid is full, so no new
      // entry can arrive in the same cycle.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_ctrl_d   = skid_ctrl_q;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = CTRL_ZERO;
      end else if (xfer_in) begin
        out_valid_d = 1'b1;
        out_ctrl_d  = In_Ctrl;
        out_data_d  = In_Data;
      end else begin
        out_valid_d = 1'b0;
        out_ctrl_d  = CTRL_ZERO;
      end
    end else if (xfer_in) begin
      // Output is stalled: park the new entry in the skid slot.
      skid_valid_d = 1'b1;
      skid_ctrl_d  = In_Ctrl;
      skid_data_d  = In_Data;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end

`else
  // ---------------------------------------------------------------------------
  // Base variant: capacity 1, combinational ready
  // ---------------------------------------------------------------------------
  // Accept when empty or when the held entry leaves this cycle, which gives
  // back-to-back transfers with no bubble.
  assign In_Ready = (~out_valid_q | Out_Ready) & ~Flush;

  always_comb begin
    out_valid_d = out_valid_q;
    out_ctrl_d  = out_ctrl_q;
    out_data_d  = out_data_q;

    if (Flush) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = CTRL_ZERO;
    end else if (xfer_in) begin
      out_valid_d = 1'b1;
      out_ctrl_d  = In_Ctrl;
      out_data_d  = In_Data;
    end else if (xfer_out) begin
      // Emptied slot shows a bubble: control cleared, data left in place.
      out_valid_d = 1'b0;
      out_ctrl_d  = CTRL_ZERO;
    end
  end
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ctrl_q  <= out_ctrl_d;
      out_data_q  <= out_data_d;
    end
  end

  assign Out_Valid = out_valid_q;
  assign Out_Ctrl  = out_ctrl_q;
  assign Out_Data  = out_data_q;

  // ---------------------------------------------------------------------------
  // Stall counter: counts cycles where an entry is held but not taken.
  // Flush does not clear it; only Reset and Stall_Clr do.
  // ---------------------------------------------------------------------------
  logic stall_inc;

  assign stall_inc = out_valid_q & ~Out_Ready;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (Clock),
    .rst   (Reset),
    .inc   (stall_inc),
    .clr   (Stall_Clr),
    .count (Stall_Count)
  );

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 133;

`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              Clock = 1'b0;
  logic              Reset, Flush, In_Valid, Out_Ready, Stall_Clr;
  logic [CTRL_W-1:0] In_Ctrl;
  logic [DATA_W-1:0] In_Data;

  logic              In_Ready, Out_Valid;
  logic [CTRL_W-1:0] Out_Ctrl;
  logic [DATA_W-1:0] Out_Data;
  logic [15:0]       Stall_Count;

  logic              In_Ready4, Out_Valid4;
  logic [CTRL_W-1:0] Out_Ctrl4;
  logic [DATA_W-1:0] Out_Data4;
  logic [3:0]        Stall_Count4;

  always #5 Clock = ~Clock;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Ctrl(In_Ctrl), .In_Data(In_Data),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Ctrl(Out_Ctrl), .Out_Data(Out_Data),
    .Stall_Count(Stall_Count), .Stall_Clr(Stall_Clr)
  );

  // Narrow-counter instance driven by the same stimulus, for saturation.
  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(In_Ready4), .In_Ctrl(In_Ctrl), .In_Data(In_Data),
    .Out_Valid(Out_Valid4), .Out_Ready(Out_Ready), .Out_Ctrl(Out_Ctrl4), .Out_Data(Out_Data4),
    .Stall_Count(Stall_Count4), .Stall_Clr(Stall_Clr)
  );

  typedef struct {
    string             name;
    logic              rst, flush, in_valid, out_ready, stall_clr;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              chk_rdy, exp_rdy;
    logic              exp_valid;
    logic [CTRL_W-1:0] exp_ctrl;
    logic [DATA_W-1:0] exp_data;
    logic [15:0]       exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input string name, input logic rst, input logic flush,
                              input logic in_valid, input logic [7:0] in_ctrl,
                              input logic [31:0] in_data, input logic out_ready,
                              input logic stall_clr, input logic chk_rdy, input logic exp_rdy,
                              input logic exp_valid, input logic [7:0] exp_ctrl,
                              input logic [31:0] exp_data, input logic [15:0] exp_cnt);
    vec_t v;
    v.name = name; v.rst = rst; v.flush = flush; v.in_valid = in_valid;
    v.in_ctrl = in_ctrl; v.in_data = DATA_W'(in_data); v.out_ready = out_ready;
    v.stall_clr = stall_clr; v.chk_rdy = chk_rdy; v.exp_rdy = exp_rdy;
    v.exp_valid = exp_valid; v.exp_ctrl = exp_ctrl; v.exp_data = DATA_W'(exp_data);
    v.exp_cnt = exp_cnt;
    vecs.push_back(v);
  endfunction

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // One vector = one clock: drive, check In_Ready before the edge, then
  // check registered outputs after it.
  task automatic apply(input vec_t v);
    Reset = v.rst; Flush = v.flush; In_Valid = v.in_valid; In_Ctrl = v.in_ctrl;
    In_Data = v.in_data; Out_Ready = v.out_ready; Stall_Clr = v.stall_clr;
    #1;
    if (v.chk_rdy) check({v.name, " in_ready"}, DATA_W'(In_Ready), DATA_W'(v.exp_rdy));
    tick();
    check({v.name, " out_valid"}, DATA_W'(Out_Valid), DATA_W'(v.exp_valid));
    check({v.name, " out_ctrl"}, DATA_W'(Out_Ctrl), DATA_W'(v.exp_ctrl));
    check({v.name, " out_data"}, Out_Data, v.exp_data);
    check({v.name, " stall_cnt"}, DATA_W'(Stall_Count), DATA_W'(v.exp_cnt));
  endtask

  initial begin
    Reset = 1'b1; Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0; Stall_Clr = 1'b0;
    In_Ctrl = '0; In_Data = '0;

    //   name        rst fl iv ctrl   data     ordy clr chk rdy               ov ctrl   data     cnt
    add("reset0",    1, 0, 1, 8'hFF, 32'h77,  0,   0,  0,  0,                0, 8'h00, 32'h0,   0);
    add("reset1",    1, 0, 1, 8'hFF, 32'h77,  0,   0,  0,  0,                0, 8'h00, 32'h0,   0);
    add("idle",      0, 0, 0, 8'h00, 32'h0,   1,   0,  1,  1,                0, 8'h00, 32'h0,   0);
    add("stream1",   0, 0, 1, 8'h11, 32'h1,   1,   0,  1,  1,                1, 8'h11, 32'h1,   0);
    add("stream2",   0, 0, 1, 8'h22, 32'h2,   1,   0,  1,  1,                1, 8'h22, 32'h2,   0);
    add("stream3",   0, 0, 1, 8'h33, 32'h3,   1,   0,  1,  1,                1, 8'h33, 32'h3,   0);
    add("stream4",   0, 0, 1, 8'h44, 32'h4,   1,   0,  1,  1,                1, 8'h44, 32'h4,   0);
    add("drain",     0, 0, 0, 8'h00, 32'h0,   1,   0,  1,  1,                0, 8'h00, 32'h4,   0);
    add("load_a5",   0, 0, 1, 8'h5A, 32'hA5,  0,   0,  1,  1,                1, 8'h5A, 32'hA5,  0);
    for (int k = 1; k <= 5; k++)
      add($sformatf("stall%0d", k),
                     0, 0, 1, 8'h6B, 32'hB6,  0,   0,  1,  SKID && (k == 1), 1, 8'h5A, 32'hA5,  16'(k));
    add("release",   0, 0, 1, 8'h6B, 32'hB6,  1,   0,  1,  !SKID,            1, 8'h6B, 32'hB6,  5);
    add("empty_b6",  0, 0, 0, 8'h00, 32'h0,   1,   0,  1,  1,                0, 8'h00, 32'hB6,  5);
    add("load_0c",   0, 0, 1, 8'h0C, 32'hC3,  0,   0,  1,  1,                1, 8'h0C, 32'hC3,  5);
    add("flush",     0, 1, 1, 8'h77, 32'hDD,  0,   0,  1,  0,                0, 8'h00, 32'hC3,  6);
    add("post_fl",   0, 0, 0, 8'h00, 32'h0,   1,   0,  1,  1,                0, 8'h00, 32'hC3,  6);
    add("clr",       0, 0, 0, 8'h00, 32'h0,   1,   1,  1,  1,                0, 8'h00, 32'hC3,  0);

    foreach (vecs[i]) apply(vecs[i]);
    Stall_Clr = 1'b0;

    // Saturation on the 4-bit counter while the 16-bit one keeps counting.
    In_Valid = 1'b1; In_Ctrl = 8'h12; In_Data = DATA_W'(32'h99); Out_Ready = 1'b0;
    tick();
    check("sat load valid", DATA_W'(Out_Valid), DATA_W'(1'b1));
    In_Valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("sat cnt4 k=%0d", k), DATA_W'(Stall_Count4), DATA_W'((k > 15) ? 15 : k));
    end
    check("sat cnt16", DATA_W'(Stall_Count), DATA_W'(20));
    check("sat data held", Out_Data, DATA_W'(32'h99));
    check("sat ctrl held", DATA_W'(Out_Ctrl), DATA_W'(8'h12));
    Stall_Clr = 1'b1;
    tick();
    check("clr wins cnt4", DATA_W'(Stall_Count4), DATA_W'(0));
    check("clr wins cnt16", DATA_W'(Stall_Count), DATA_W'(0));
    Stall_Clr = 1'b0;
    tick();
    check("recount cnt4", DATA_W'(Stall_Count4), DATA_W'(1));
    check("recount cnt16", DATA_W'(Stall_Count), DATA_W'(1));

    // Reset while stalled (skid full in the skid build).
    In_Valid = 1'b1; In_Ctrl = 8'h21; In_Data = DATA_W'(32'h2B);
    #1;
    check("pre-rst in_ready", DATA_W'(In_Ready), DATA_W'(SKID));
    tick();
    check("pre-rst data", Out_Data, DATA_W'(32'h99));
    In_Valid = 1'b0; Reset = 1'b1;
    tick();
    check("rst valid", DATA_W'(Out_Valid), DATA_W'(0));
    check("rst ctrl", DATA_W'(Out_Ctrl), DATA_W'(0));
    check("rst data", Out_Data, DATA_W'(0));
    check("rst cnt", DATA_W'(Stall_Count), DATA_W'(0));
    Reset = 1'b0; Out_Ready = 1'b1;
    #1;
    check("post-rst in_ready", DATA_W'(In_Ready), DATA_W'(1));
    tick();
    check("post-rst valid", DATA_W'(Out_Valid), DATA_W'(0));
    check("post-rst ctrl", DATA_W'(Out_Ctrl), DATA_W'(0));
    check("post-rst data", Out_Data, DATA_W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_stage_reg

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generalised inter-stage pipeline register, successor to the fixed EX/MEM register. Carries a parametrised control bundle and data bundle between stages with a valid/ready handshake, synchronous flush that inserts a bubble, and a saturating stall-cycle counter. Instanced between every pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) in place of the per-stage hand-written registers.

Parameters:
CTRL_W, 8, width of control bundle (MemRead, MemWrite, RegWrite, ByteSel, MemToReg, ...); zeroed on flush.
DATA_W, 133, width of data bundle (ALUResult, Instruction, PC, WriteData, RegDest, ...); held on flush.
CNT_W, 16, width of stall counter.

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
Flush  in  1  drop held entries, insert bubble
In_Valid  in  1  upstream entry valid
In_Ready  out  1  stage can accept this cycle
In_Ctrl  in  CTRL_W  control bundle in
In_Data  in  DATA_W  data bundle in
Out_Valid  out  1  output entry valid
Out_Ready  in  1  downstream accepts
Out_Ctrl  out  CTRL_W  registered control bundle
Out_Data  out  DATA_W  registered data bundle
Stall_Count  out  CNT_W  cycles with Out_Valid=1 and Out_Ready=0, saturating
Stall_Clr  in  1  synchronous clear of Stall_Count

Behaviour:
- One clock (Clock); reset is synchronous and active-high (Reset). Reset values: Out_Valid=0, Out_Ctrl=0, Out_Data=0, Stall_Count=0, skid slot empty/zero; In_Ready=1 the cycle after reset release.
- Transfer in: In_Valid & In_Ready at a rising edge. Transfer out: Out_Valid & Out_Ready.
- Latency 1 cycle: accepted entry appears on Out_* the next cycle.
- Base (no skid): In_Ready = ~Out_Valid | Out_Ready (combinational). On edge: if transfer-in, Out_* <= In_*, Out_Valid<=1; else if transfer-out, Out_Valid<=0, Out_Ctrl<=0, Out_Data held.
- Hold: Out_Valid=1, Out_Ready=0 -> all Out_* stable, no input accepted.
- Simultaneous transfer-in and transfer-out: new entry replaces old, Out_Valid stays 1, zero bubbles.
- Priority per edge: Reset > Flush > normal operation.
- Flush: Out_Valid<=0, Out_Ctrl<=0, skid emptied; Out_Data held; In_Ready forced 0 during the Flush cycle (no entry accepted); normal next cycle.
- Reset mid-stall: overrides; held entry discarded.
- Stall_Count: increments when Out_Valid & ~Out_Ready; saturates at 2^CNT_W-1, no wrap. Stall_Clr zeroes it (Reset also); Stall_Clr wins over increment on same edge. Flush does not clear it.
- Out_Ctrl is 0 whenever Out_Valid=0, so downstream may consume control bits without gating.

Optional Feature:
PIPE_SKID_EN. Defined: adds one skid slot (ctrl+data+valid); In_Ready = skid empty (registered, no combinational path from Out_Ready). Input accepted while output stalled goes to skid; when output transfers and skid full, skid moves to Out_* next edge, skid empties; capacity 2 entries, order preserved. Undefined: no skid, combinational In_Ready as above, capacity 1.

Decomposition:
- Shared package pipe_pkg: CTRL_W/DATA_W defaults per stage (IFID_*, IDEX_*, EXMEM_*, MEMWB_*), control-bundle field offsets (MEMREAD_BIT, MEMWRITE_BIT, REGWRITE_BIT, BYTESEL_LSB, MEMTOREG_LSB), CTRL_BUBBLE=0.
- One sub-module: sat_counter (CNT_W, inc, clr, saturating) for Stall_Count. Skid slot stays inline.

Test Plan:
- Reset held 2 cycles with In_Valid=1, In_Ctrl=8'hFF -> Out_Valid=0, Out_Ctrl=0, Out_Data=0, Stall_Count=0; In_Ready=1 after release.
- Stream 4 entries (Data=1..4, Ctrl=8'h11..8'h44), Out_Ready=1 -> each on Out_* exactly 1 cycle after acceptance, no bubbles.
- Entry Data=0xA5, Out_Ready=0 for 5 cycles -> Out_* stable, Stall_Count=5; base: In_Ready=0; with PIPE_SKID_EN: next entry 0xB6 accepted into skid, then In_Ready=0; release -> 0xA5 then 0xB6 in order.
- Flush while Out_Valid=1, Out_Ctrl=8'h0C, In_Valid=1 -> next cycle Out_Valid=0, Out_Ctrl=0, Out_Data unchanged, incoming entry dropped.
- CNT_W=4, Out_Ready=0 for 20 cycles -> Stall_Count saturates at 15; Stall_Clr pulse with stall ongoing -> 0 next cycle, then counts from 1.
- Reset asserted during stall with skid full -> both entries dropped, Out_Valid=0, Out_Ctrl=0, Out_Data=0, skid empty.
